macc_job_scheduler: RTL and testbench

- Round-robin scheduler that shares one obfuscated HLS multiply-accumulate core (ap_ctrl_hs handshake: ap_start/ap_done/ap_idle/ap_ready) among N requesters.
- Registers the granted requester's operand bundle, drives ap_start, and captures the three core results on their ap_vld strobes.
- Returns the results to the requester as a one-cycle response.
- A watchdog aborts jobs that never complete, e.g. a core locked with a wrong key, and flags them.

---
 rtl/macc_job_scheduler.sv | 132 +++++++++++++
 tb/tb_macc_job_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_job_scheduler.sv
// Round-robin scheduler sharing one ap_ctrl_hs multiply-accumulate core among N_REQ requesters,
// with a per-job watchdog that aborts and flags jobs the core never finishes.
module macc_job_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned NWORDS      = 21,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*NWORDS*32-1:0] req_ops,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_vld,
  output logic                      rsp_err,
  output logic [31:0]               rsp_out13,
  output logic [31:0]               rsp_out30,
  output logic [31:0]               rsp_out31,
  output logic [NWORDS*32-1:0]      core_ops,
  output logic                      core_ap_start,
  input  logic                      core_ap_done,
  input  logic                      core_ap_idle,
  input  logic                      core_ap_ready,
  input  logic [31:0]               core_out13,
  input  logic [31:0]               core_out30,
  input  logic [31:0]               core_out31,
  input  logic                      core_out13_vld,
  input  logic                      core_out30_vld,
  input  logic                      core_out31_vld,
  output logic                      busy,
  output logic                      err_sticky
);

  localparam int unsigned OPS_W = NWORDS * 32;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur_idx;
  logic [CNT_W-1:0]   cnt;
  logic               pick_vld_c;
  logic [IDX_W-1:0]   pick_idx_c;
  int unsigned        cand;

  // ap_ready always coincides with ap_done on this core, so it carries no extra information.
  logic unused_ready;
  assign unused_ready = core_ap_ready;

  // Round-robin search: first pending requester after the last one served, with wrap.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    cand       = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_grant) + off) % N_REQ;
      if (!pick_vld_c && req[IDX_W'(cand)]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state         <= ST_IDLE;
      last_grant    <= IDX_W'(N_REQ - 1);
      cur_idx       <= '0;
      cnt           <= '0;
      gnt           <= '0;
      rsp_vld       <= '0;
      rsp_err       <= 1'b0;
      rsp_out13     <= '0;
      rsp_out30     <= '0;
      rsp_out31     <= '0;
      core_ops      <= '0;
      core_ap_start <= 1'b0;
      busy          <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld_c && core_ap_idle) begin
            gnt           <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_c;
            cur_idx       <= pick_idx_c;
            core_ops      <= req_ops[32'(pick_idx_c)*OPS_W +: OPS_W];
            core_ap_start <= 1'b1;
            rsp_out13     <= '0;
            rsp_out30     <= '0;
            rsp_out31     <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (core_out13_vld) rsp_out13 <= core_out13;
          if (core_out30_vld) rsp_out30 <= core_out30;
          if (core_out31_vld) rsp_out31 <= core_out31;
          // Done takes priority over a simultaneous watchdog expiry.
          if (core_ap_done) begin
            core_ap_start <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_vld       <= gnt;
            state         <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            core_ap_start <= 1'b0;
            rsp_err       <= 1'b1;
            err_sticky    <= 1'b1;
            rsp_out13     <= '0;
            rsp_out30     <= '0;
            rsp_out31     <= '0;
            rsp_vld       <= gnt;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          gnt        <= '0;
          rsp_vld    <= '0;
          last_grant <= cur_idx;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_macc_job_scheduler.sv
// Bench for macc_job_scheduler: a behavioural core with programmable done latency plus a
// round-robin/latency reference model; directed scenarios followed by randomized jobs.
module tb_macc_job_scheduler;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned NWORDS = 21;
  localparam int unsigned TO     = 16;
  localparam int unsigned CW     = NWORDS * 32;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*CW-1:0]       req_ops;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_vld;
  logic                      rsp_err;
  logic [31:0]               rsp_out13, rsp_out30, rsp_out31;
  logic [CW-1:0]             core_ops;
  logic                      core_ap_start;
  logic                      core_ap_done, core_ap_idle, core_ap_ready;
  logic [31:0]               res13, res30, res31;
  logic                      core_out13_vld, core_out30_vld, core_out31_vld;
  logic                      busy, err_sticky;
  logic                      idle_en;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int run_cyc  = 0;
  int core_lat = 3;
  int grant_cyc = 0;
  int m_last   = N_REQ - 1;
  logic m_sticky = 1'b0;

  macc_job_scheduler #(.N_REQ(N_REQ), .NWORDS(NWORDS), .TIMEOUT_CYC(TO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req(req), .req_ops(req_ops),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .rsp_out13(rsp_out13), .rsp_out30(rsp_out30), .rsp_out31(rsp_out31),
    .core_ops(core_ops), .core_ap_start(core_ap_start),
    .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle), .core_ap_ready(core_ap_ready),
    .core_out13(res13), .core_out30(res30), .core_out31(res31),
    .core_out13_vld(core_out13_vld), .core_out30_vld(core_out30_vld), .core_out31_vld(core_out31_vld),
    .busy(busy), .err_sticky(err_sticky)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Behavioural core: done (with out30/out31) core_lat cycles into the start window, out13 one earlier.
  always @(posedge ap_clk) run_cyc <= core_ap_start ? run_cyc + 1 : 0;
  assign core_ap_done   = core_ap_start && (core_lat >= 0) && (run_cyc == core_lat);
  assign core_out30_vld = core_ap_done;
  assign core_out31_vld = core_ap_done;
  assign core_out13_vld = core_ap_start && (core_lat >= 0) &&
                          (run_cyc == ((core_lat > 0) ? core_lat - 1 : 0));
  assign core_ap_ready  = core_ap_done;
  assign core_ap_idle   = idle_en;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] r);
    for (int off = 1; off <= N_REQ; off++) begin
      int i = (last + off) % N_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_ops;
    for (int w = 0; w < N_REQ * NWORDS; w++) req_ops[w*32 +: 32] = $urandom();
  endtask

  task automatic rand_res;
    res13 = $urandom();
    res30 = $urandom();
    res31 = $urandom();
  endtask

  // One job from the IDLE decision cycle through the cycle after its response.
  task automatic run_job(input logic [N_REQ-1:0] rv, input int lat);
    int idx, k, exp_k;
    logic exp_err;
    logic [N_REQ-1:0] oh;
    logic [CW-1:0] exp_ops;
    logic [31:0] e13, e30, e31;
    req      = rv;
    core_lat = lat;
    rand_ops();
    idx     = rr_pick(m_last, rv);
    oh      = N_REQ'(1) << idx;
    exp_ops = req_ops[idx*CW +: CW];
    exp_err = !(lat >= 0 && lat <= int'(TO) - 1);
    exp_k   = exp_err ? int'(TO) + 1 : lat + 2;
    e13 = exp_err ? 32'h0 : res13;
    e30 = exp_err ? 32'h0 : res30;
    e31 = exp_err ? 32'h0 : res31;
    tick();
    grant_cyc = cyc;
    chk("gnt_at_start", CW'(gnt), CW'(oh));
    chk("start_high", CW'(core_ap_start), CW'(1'b1));
    chk("busy_run", CW'(busy), CW'(1'b1));
    // Inputs changing after the grant must not disturb the job.
    req = N_REQ'($urandom());
    rand_ops();
    k = 1;
    while (rsp_vld === '0 && k < int'(TO) + 8) begin
      chk("gnt_hold", CW'(gnt), CW'(oh));
      tick();
      k++;
    end
    chk("rsp_latency", CW'(k), CW'(exp_k));
    chk("rsp_vld", CW'(rsp_vld), CW'(oh));
    chk("rsp_err", CW'(rsp_err), CW'(exp_err));
    chk("rsp_out13", CW'(rsp_out13), CW'(e13));
    chk("rsp_out30", CW'(rsp_out30), CW'(e30));
    chk("rsp_out31", CW'(rsp_out31), CW'(e31));
    chk("gnt_resp", CW'(gnt), CW'(oh));
    chk("start_low_resp", CW'(core_ap_start), CW'(1'b0));
    chk("core_ops", core_ops, exp_ops);
    m_sticky = m_sticky | exp_err;
    chk("err_sticky", CW'(err_sticky), CW'(m_sticky));
    tick();
    chk("rsp_vld_clear", CW'(rsp_vld), CW'(0));
    chk("gnt_clear", CW'(gnt), CW'(0));
    chk("busy_idle", CW'(busy), CW'(1'b0));
    chk("rsp_out13_hold", CW'(rsp_out13), CW'(e13));
    m_last = idx;
    req = '0;
  endtask

  initial begin
    int prev;
    int lat;
    logic [N_REQ-1:0] rv;
    ap_rst  = 1'b1;
    req     = '0;
    req_ops = '0;
    idle_en = 1'b1;
    res13 = '0; res30 = '0; res31 = '0;
    repeat (3) tick();
    chk("rst_gnt", CW'(gnt), CW'(0));
    chk("rst_start", CW'(core_ap_start), CW'(1'b0));
    chk("rst_busy", CW'(busy), CW'(1'b0));
    chk("rst_ops", core_ops, CW'(0));
    ap_rst = 1'b0;
    tick();
    chk("post_rst_rsp_vld", CW'(rsp_vld), CW'(0));
    chk("post_rst_sticky", CW'(err_sticky), CW'(1'b0));
    chk("post_rst_err", CW'(rsp_err), CW'(1'b0));

    // Single job on requester 0 with fixed results.
    res13 = 32'h5; res30 = 32'h10; res31 = 32'h20;
    run_job(4'b0001, 3);

    // All requesting: rotate through requesters, one job every 6 cycles.
    prev = -1;
    for (int j = 0; j < 5; j++) begin
      rand_res();
      run_job(4'b1111, 3);
      if (prev >= 0) chk("throughput_gap", CW'(grant_cyc - prev), CW'(6));
      prev = grant_cyc;
    end

    // Fairness with two requesters after serving requester 0.
    rand_res(); run_job(4'b0001, 3);
    rand_res(); run_job(4'b0101, 3);
    rand_res(); run_job(4'b0101, 3);

    // Watchdog abort, then done exactly on the last counter value, then one cycle too late.
    rand_res(); run_job(4'b0010, -1);
    rand_res(); run_job(4'b1000, int'(TO) - 1);
    rand_res(); run_job(4'b1000, int'(TO));

    // Core busy elsewhere: no grant until idle returns.
    idle_en = 1'b0;
    req = 4'b0010;
    repeat (3) begin
      tick();
      chk("no_grant_not_idle", CW'(gnt), CW'(0));
      chk("busy_not_idle", CW'(busy), CW'(1'b0));
    end
    idle_en = 1'b1;
    rand_res(); run_job(4'b0010, 3);

    // Reset in the middle of a job.
    req = 4'b0100;
    core_lat = 3;
    tick(); tick(); tick();
    chk("pre_rst_start", CW'(core_ap_start), CW'(1'b1));
    ap_rst = 1'b1;
    #1;
    chk("midrst_start", CW'(core_ap_start), CW'(1'b0));
    chk("midrst_gnt", CW'(gnt), CW'(0));
    chk("midrst_busy", CW'(busy), CW'(1'b0));
    chk("midrst_sticky", CW'(err_sticky), CW'(1'b0));
    m_last = N_REQ - 1;
    m_sticky = 1'b0;
    tick();
    ap_rst = 1'b0;
    chk("midrst_no_rsp", CW'(rsp_vld), CW'(0));
    rand_res(); run_job(4'b0100, 3);

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      rv = N_REQ'($urandom_range(1, 15));
      case ($urandom_range(0, 9))
        0:       lat = -1;
        1:       lat = int'(TO) - 1;
        2:       lat = int'(TO);
        default: lat = int'($urandom_range(0, 6));
      endcase
      rand_res();
      run_job(rv, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
